// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, character-size
// constants and the small helpers used when a frame is launched.
package uart_pkg;

  // Smallest character the line supports; wls adds to this.
  localparam int MIN_BITS = 5;
  // Width of a data-bit count (holds up to 9).
  localparam int NBW = 4;
  // Widest character the parity helper accepts.
  localparam int PAR_W = 9;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  // Parity bit for a character whose unused upper bits are already zero.
  // {stick,eps}: 00 odd, 01 even, 10 forced 1, 11 forced 0.
  function automatic logic parity_bit(input logic [PAR_W-1:0] data,
                                      input logic stick,
                                      input logic eps);
    logic p;
    case ({stick, eps})
      2'b00:   p = ~^data;
      2'b01:   p = ^data;
      2'b10:   p = 1'b1;
      default: p = 1'b0;
    endcase
    return p;
  endfunction

  // Character length selected by wls, clipped to what the instance supports.
  function automatic logic [NBW-1:0] char_bits(input logic [1:0] wls,
                                               input int max_bits);
    logic [NBW-1:0] n;
    n = NBW'(MIN_BITS) + {2'b00, wls};
    if (int'(n) > max_bits) n = NBW'(max_bits);
    return n;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Loadable down-counter paced by baud ticks. Reports when it has reached
// zero so the owning FSM knows the current bit period has run out.
module uart_bit_timer #(
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          zero
);

  logic [CW-1:0] count;

  // Load wins; otherwise step down once per tick and rest at zero.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: clocked state uses <= so every flop samples pre-edge values.
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (tick && !zero) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/uart_tx_engine.sv
// 16550-class serial transmitter. Pulls characters from the TX FIFO and
// shifts out start, data (LSB first), optional parity and stop bits, all
// paced by an oversampled baud tick. Line format is captured at frame start.
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_MAX   = 8,
  parameter int CW         = $clog2(OVERSAMPLE * 2)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                baud_pulse,
  input  logic                tx_en,
  input  logic                fifo_empty,
  input  logic [DATA_MAX-1:0] fifo_dout,
  output logic                fifo_pop,
  input  logic [1:0]          wls,
  input  logic                pen,
  input  logic                eps,
  input  logic                stick,
  input  logic                stb,
  input  logic                set_break,
  output logic                tx,
  output logic                busy,
  output logic                sreg_empty,
  output logic                frame_done
);

  tx_state_t state, state_next;

  // Frame-launch view of the current FIFO head and line controls.
  logic [DATA_MAX-1:0] data_masked;
  logic [NBW-1:0]      nbits_sel;
  logic [CW-1:0]       stop_sel;

  // Per-frame captured configuration and shifting datapath.
  logic [DATA_MAX-1:0] shift_reg;
  logic [NBW-1:0]      bit_cnt;
  logic [NBW-1:0]      cfg_nbits;
  logic                cfg_pen;
  logic                cfg_par;
  logic [CW-1:0]       cfg_stop;
  logic                tx_bit;

  // Blocks pops while reset is held and for the first clock after it.
  logic                armed;

  // FSM control strobes.
  logic                timer_load;
  logic [CW-1:0]       timer_val;
  logic                timer_zero;
  logic                can_start;
  logic                launch;
  logic                shift_out;
  logic                send_par;
  logic                send_stop;

  uart_bit_timer #(.CW(CW)) u_bit_timer (
    .clk      (clk),
    .rst      (rst),
    .tick     (baud_pulse),
    .load     (timer_load),
    .load_val (timer_val),
    .zero     (timer_zero)
  );

  assign nbits_sel = char_bits(wls, DATA_MAX);
  assign can_start = armed && tx_en && !fifo_empty;
  assign fifo_pop  = launch;

  // Keep only the selected number of low data bits of the FIFO head.
  always_comb begin
    data_masked = '0;
    for (int i = 0; i < DATA_MAX; i++) begin
      if (i < int'(nbits_sel)) data_masked[i] = fifo_dout[i];
    end
  end

  // Stop length in ticks minus one: 1, 1.5 (5-bit chars) or 2 bit periods.
  always_comb begin
    stop_sel = CW'(OVERSAMPLE - 1);
    if (stb) begin
      if (nbits_sel == NBW'(MIN_BITS)) stop_sel = CW'(3 * OVERSAMPLE / 2 - 1);
      else                             stop_sel = CW'(2 * OVERSAMPLE - 1);
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state and control strobes; all movement happens on a baud tick.
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    state_next = state;
    timer_load = 1'b0;
    timer_val  = '0;
    launch     = 1'b0;
    shift_out  = 1'b0;
    send_par   = 1'b0;
    send_stop  = 1'b0;
    frame_done = 1'b0;
    if (baud_pulse) begin
      case (state)
        IDLE: begin
          launch = can_start;
        end
        START: begin
          if (timer_zero) begin
            shift_out  = 1'b1;
            timer_load = 1'b1;
            timer_val  = CW'(OVERSAMPLE - 1);
            state_next = DATA;
          end
        end
        DATA: begin
          if (timer_zero) begin
            timer_load = 1'b1;
            if (bit_cnt != cfg_nbits) begin
              shift_out = 1'b1;
              timer_val = CW'(OVERSAMPLE - 1);
            end else if (cfg_pen) begin
              send_par   = 1'b1;
              timer_val  = CW'(OVERSAMPLE - 1);
              state_next = PARITY;
            end else begin
              send_stop  = 1'b1;
              timer_val  = cfg_stop;
              state_next = STOP;
            end
          end
        end
        PARITY: begin
          if (timer_zero) begin
            send_stop  = 1'b1;
            timer_load = 1'b1;
            timer_val  = cfg_stop;
            state_next = STOP;
          end
        end
        STOP: begin
          if (timer_zero) begin
            frame_done = 1'b1;
            state_next = IDLE;
            // The closing stop tick doubles as the idle decision, so a
            // waiting character starts with no idle gap.
            launch     = can_start;
          end
        end
        default: state_next = IDLE;
      endcase
    end
    if (launch) begin
      timer_load = 1'b1;
      timer_val  = CW'(OVERSAMPLE - 1);
      state_next = START;
    end
  end

  // Capture the character and its format at launch, then shift it out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg  <= '0;
      bit_cnt    <= '0;
      cfg_nbits  <= '0;
      cfg_pen    <= 1'b0;
      cfg_par    <= 1'b0;
      cfg_stop   <= '0;
      tx_bit     <= 1'b1;
      busy       <= 1'b0;
      sreg_empty <= 1'b1;
    end else if (launch) begin
      shift_reg  <= data_masked;
      bit_cnt    <= '0;
      cfg_nbits  <= nbits_sel;
      cfg_pen    <= pen;
      cfg_par    <= parity_bit(PAR_W'(data_masked), stick, eps);
      cfg_stop   <= stop_sel;
      tx_bit     <= 1'b0;
      busy       <= 1'b1;
      sreg_empty <= 1'b0;
    end else begin
      if (shift_out) begin
        tx_bit    <= shift_reg[0];
        shift_reg <= shift_reg >> 1;
        bit_cnt   <= bit_cnt + 1'b1;
      end
      if (send_par) tx_bit <= cfg_par;
      if (send_stop) begin
        tx_bit     <= 1'b1;
        sreg_empty <= 1'b1;
      end
      if (frame_done) busy <= 1'b0;
    end
  end

  // Pop qualification re-arms one clock after reset is released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) armed <= 1'b0;
    else     armed <= 1'b1;
  end

  // Registered pad driver; break overrides the line without touching framing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tx <= 1'b1;
    else     tx <= tx_bit & ~set_break;
  end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Self-checking bench for uart_tx_engine. A queue-based reference model
// expands each launched character into its per-tick line levels and tracks
// when frames start and end; the bench also plays the role of the TX FIFO.
module tb_uart_tx_engine;

  localparam int OS   = 16;
  localparam int DMAX = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            baud_pulse = 1'b0;
  logic            tx_en = 1'b0;
  logic            fifo_empty = 1'b1;
  logic [DMAX-1:0] fifo_dout = '0;
  logic            fifo_pop;
  logic [1:0]      wls = 2'd3;
  logic            pen = 1'b0;
  logic            eps = 1'b0;
  logic            stick = 1'b0;
  logic            stb = 1'b0;
  logic            set_break = 1'b0;
  logic            tx;
  logic            busy;
  logic            sreg_empty;
  logic            frame_done;

  always #5 clk = ~clk;

  uart_tx_engine #(.OVERSAMPLE(OS), .DATA_MAX(DMAX)) dut (
    .clk        (clk),
    .rst        (rst),
    .baud_pulse (baud_pulse),
    .tx_en      (tx_en),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_pop   (fifo_pop),
    .wls        (wls),
    .pen        (pen),
    .eps        (eps),
    .stick      (stick),
    .stb        (stb),
    .set_break  (set_break),
    .tx         (tx),
    .busy       (busy),
    .sreg_empty (sreg_empty),
    .frame_done (frame_done)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  bit              exp_line[$];
  logic [DMAX-1:0] fifo_q[$];
  bit              in_frame = 1'b0;
  int              cur_stop = 0;
  bit              brk_req = 1'b0;
  int              obs_pops, obs_done, busy_ticks;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_fifo();
    fifo_empty = (fifo_q.size() == 0);
    fifo_dout  = fifo_empty ? '0 : fifo_q[0];
  endtask

  // Expand one character into its line levels, one entry per baud tick.
  task automatic build_frame(input logic [DMAX-1:0] w);
    int n;
    int ones;
    bit p;
    n = 5 + int'(wls);
    if (n > DMAX) n = DMAX;
    ones = 0;
    for (int k = 0; k < OS; k++) exp_line.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      ones += int'(w[i]);
      for (int k = 0; k < OS; k++) exp_line.push_back(w[i]);
    end
    if (pen) begin
      if (stick)    p = !eps;
      else if (eps) p = (ones % 2) == 1;
      else          p = (ones % 2) == 0;
      for (int k = 0; k < OS; k++) exp_line.push_back(p);
    end
    cur_stop = !stb ? OS : ((n == 5) ? 3 * OS / 2 : 2 * OS);
    for (int k = 0; k < cur_stop; k++) exp_line.push_back(1'b1);
  endtask

  // One baud tick with a random gap of idle clocks in front of it.
  task automatic do_tick();
    bit lvl, done_exp, launch, popped;
    set_break = brk_req;
    repeat ($urandom_range(1, 3)) @(negedge clk);
    lvl = (exp_line.size() > 0) ? exp_line[0] : 1'b1;
    check("tx", tx, lvl & ~brk_req);
    check("busy", busy, in_frame);
    check("sreg_empty", sreg_empty, !in_frame || (exp_line.size() <= cur_stop));
    if (busy) busy_ticks++;
    if (exp_line.size() > 0) void'(exp_line.pop_front());
    done_exp = in_frame && (exp_line.size() == 0);
    if (done_exp) in_frame = 1'b0;
    launch = !in_frame && tx_en && (fifo_q.size() > 0);
    baud_pulse = 1'b1;
    #1;
    check("fifo_pop", fifo_pop, launch);
    check("frame_done", frame_done, done_exp);
    popped = fifo_pop;
    if (popped) obs_pops++;
    if (frame_done) obs_done++;
    if (launch) begin
      build_frame(fifo_q[0]);
      in_frame = 1'b1;
    end
    @(negedge clk);
    baud_pulse = 1'b0;
    if (popped && fifo_q.size() > 0) begin
      void'(fifo_q.pop_front());
      drive_fifo();
    end
  endtask

  task automatic run_until_idle(input int max_ticks);
    int g;
    g = 0;
    while ((in_frame || fifo_q.size() > 0) && g < max_ticks) begin
      do_tick();
      g++;
    end
    check("idle_reached", 32'(g < max_ticks), 32'd1);
  endtask

  task automatic clear_counts();
    obs_pops = 0;
    obs_done = 0;
    busy_ticks = 0;
  endtask

  task automatic directed(input string tag, input logic [DMAX-1:0] w, input logic [1:0] wl,
                          input bit pe, input bit ep, input bit st, input bit sb,
                          input int exp_busy);
    wls = wl; pen = pe; eps = ep; stick = st; stb = sb; tx_en = 1'b1;
    clear_counts();
    fifo_q.push_back(w);
    drive_fifo();
    run_until_idle(1000);
    check({tag, "_pops"}, obs_pops, 1);
    check({tag, "_done"}, obs_done, 1);
    check({tag, "_busy_ticks"}, busy_ticks, exp_busy);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit pop_seen;
    obs_pops = 0; obs_done = 0; busy_ticks = 0;

    // Reset values while reset is held, with a tick and a waiting word.
    fifo_q.push_back(8'h55);
    drive_fifo();
    tx_en = 1'b1;
    baud_pulse = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_sreg_empty", sreg_empty, 1);
    check("rst_frame_done", frame_done, 0);
    check("rst_fifo_pop", fifo_pop, 0);
    baud_pulse = 1'b0;
    tx_en = 1'b0;
    rst = 1'b0;
    fifo_q.delete();
    drive_fifo();

    // 8N1, 7E2, 5-bit stick parity with 1.5 stop bits.
    directed("8n1_a5", 8'hA5, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 160);
    directed("7e2_41", 8'h41, 2'd2, 1'b1, 1'b1, 1'b0, 1'b1, 176);
    directed("5s15_1f", 8'h1F, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1, 136);
    directed("6o1_masked", 8'hEB, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 144);

    // Three queued words go out back to back without any idle tick.
    wls = 2'd3; pen = 1'b0; stb = 1'b0; tx_en = 1'b1;
    clear_counts();
    fifo_q.push_back(8'h00); fifo_q.push_back(8'hFF); fifo_q.push_back(8'h3C);
    drive_fifo();
    run_until_idle(2000);
    check("b2b_pops", obs_pops, 3);
    check("b2b_done", obs_done, 3);
    check("b2b_busy_ticks", busy_ticks, 480);

    // tx_en low holds off a waiting word; raising it starts the frame.
    tx_en = 1'b0;
    clear_counts();
    fifo_q.push_back(8'h96);
    drive_fifo();
    repeat (20) do_tick();
    check("txen_hold_pops", obs_pops, 0);
    tx_en = 1'b1;
    run_until_idle(1000);
    check("txen_pops", obs_pops, 1);

    // Break pulse mid-DATA forces the line low but leaves the timing alone.
    clear_counts();
    fifo_q.push_back(8'hC3);
    drive_fifo();
    repeat (40) do_tick();
    brk_req = 1'b1;
    repeat (6) do_tick();
    brk_req = 1'b0;
    run_until_idle(1000);
    check("break_busy_ticks", busy_ticks, 160);
    check("break_done", obs_done, 1);

    // Reset mid-DATA: line idles at once and no pop happens during reset.
    clear_counts();
    fifo_q.push_back(8'h5A); fifo_q.push_back(8'h81);
    drive_fifo();
    repeat (50) do_tick();
    rst = 1'b1;
    baud_pulse = 1'b1;
    #1;
    check("rstmid_tx", tx, 1);
    check("rstmid_busy", busy, 0);
    check("rstmid_sreg_empty", sreg_empty, 1);
    check("rstmid_fifo_pop", fifo_pop, 0);
    @(negedge clk);
    check("rstmid_fifo_pop_held", fifo_pop, 0);
    baud_pulse = 1'b0;
    rst = 1'b0;
    exp_line.delete();
    in_frame = 1'b0;
    clear_counts();
    run_until_idle(1000);
    check("rstmid_pops", obs_pops, 1);
    check("rstmid_done", obs_done, 1);

    // Random words, formats changing mid-frame and tx_en toggling.
    clear_counts();
    for (int f = 0; f < 20; f++) fifo_q.push_back(DMAX'($urandom));
    drive_fifo();
    for (int t = 0; t < 4000 && (in_frame || fifo_q.size() > 0); t++) begin
      if ($urandom_range(0, 7) == 0) begin
        wls   = 2'($urandom);
        pen   = 1'($urandom);
        eps   = 1'($urandom);
        stick = 1'($urandom);
        stb   = 1'($urandom);
      end
      tx_en = ($urandom_range(0, 9) != 0);
      do_tick();
    end
    tx_en = 1'b1;
    run_until_idle(2000);
    check("rand_pops", obs_pops, 20);
    check("rand_done", obs_done, 20);

    // baud_pulse held high: every clock is a tick, so 8N1 is 160 clocks.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_line.delete();
    in_frame = 1'b0;
    wls = 2'd3; pen = 1'b0; stb = 1'b0; tx_en = 1'b1;
    fifo_q.push_back(8'h3C);
    drive_fifo();
    @(negedge clk);
    clear_counts();
    baud_pulse = 1'b1;
    for (int c = 0; c < 400; c++) begin
      #1;
      if (busy) busy_ticks++;
      if (frame_done) obs_done++;
      if (fifo_pop) obs_pops++;
      pop_seen = fifo_pop;
      @(negedge clk);
      if (pop_seen && fifo_q.size() > 0) begin
        void'(fifo_q.pop_front());
        drive_fifo();
      end
    end
    baud_pulse = 1'b0;
    check("cont_busy_clks", busy_ticks, 160);
    check("cont_done", obs_done, 1);
    check("cont_pops", obs_pops, 1);
    check("cont_tx_idle", tx, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
